test_sys_top_qsys_key_pio_in8: RTL and testbench



---
 rtl/test_sys_top_qsys_key_pio_in8_if.sv | 17 +
 rtl/test_sys_top_qsys_key_pio_in8.sv | 139 +++++++++++++
 tb/tb_test_sys_top_qsys_key_pio_in8.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/test_sys_top_qsys_key_pio_in8_if.sv
// Avalon-MM register-window bundle for the key input PIO.
//   address    : word address of the 4-word register window
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : zero-wait-state read data (combinational, ignores chipselect)
// master modport drives the bus, slave modport is the PIO side.
interface test_sys_top_qsys_key_pio_in8_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/test_sys_top_qsys_key_pio_in8.sv
// Key / switch input PIO with per-bit edge capture and maskable level irq.
// Optional debounce is compiled in with the macro KEY_PIO_DEBOUNCE_EN.
//
// Ports
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   avs      : Avalon-MM slave register window (see interface file)
//   in_port  : WIDTH external inputs, asynchronous to clk
//   irq      : level interrupt, |(EDGECAPTURE & IRQMASK)
//
// Register map (WIDTH bits, upper bits read 0)
//   0 DATA        ro   debounced/synchronized input state
//   1 -           ro   reads 0
//   2 IRQMASK     rw
//   3 EDGECAPTURE r/w1c, a coincident edge wins over the clear

// One input bit: synchronizer, stable register and edge qualifier.
module key_pio_lane #(
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic stable_o,
  output logic edge_o
);
  logic sync1_q, sync2_q, stable_q, stable_d;
  logic rise, fall;

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while sync2 disagrees with stable; any agreement
  // (including a glitch ending) restarts the count from zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync2_q;
      else                                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
`else
  wire unused_dbc = (DEBOUNCE_CYCLES > 0);
  assign stable_d = sync2_q;
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= in_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
    end

  // Looking at stable_d lets the capture bit set on the same edge stable moves.
  assign rise = ~stable_q &  stable_d;
  assign fall =  stable_q & ~stable_d;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_o = rise;
      1:       edge_o = fall;
      default: edge_o = rise | fall;
    endcase
  end

  assign stable_o = stable_q;
endmodule

module test_sys_top_qsys_key_pio_in8 #(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  test_sys_top_qsys_key_pio_in8_if.slave  avs,
  input  logic [WIDTH-1:0]                in_port,
  output logic                            irq
);
  logic [WIDTH-1:0] stable, edge_hit;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic             wr;

  key_pio_lane #(.EDGE_TYPE(EDGE_TYPE), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [WIDTH-1:0] (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_i     (in_port),
    .stable_o (stable),
    .edge_o   (edge_hit)
  );

  assign wr = avs.chipselect & ~avs.write_n;

  // Only WIDTH bits of writedata are meaningful.
  wire unused_wd = ^avs.writedata;

  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr && avs.address == 2'd2) irqmask_d = avs.writedata[WIDTH-1:0];
    if (wr && avs.address == 2'd3) edgecap_d = edgecap_q & ~avs.writedata[WIDTH-1:0];
    // OR the new edges in last so set beats a simultaneous clear.
    edgecap_d = edgecap_d | edge_hit;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end

  // Zero-extend by slice so WIDTH == 32 needs no zero-width replication.
  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      2'd0:    avs.readdata[WIDTH-1:0] = stable;
      2'd2:    avs.readdata[WIDTH-1:0] = irqmask_q;
      2'd3:    avs.readdata[WIDTH-1:0] = edgecap_q;
      default: avs.readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);
endmodule

// File: tb/tb_test_sys_top_qsys_key_pio_in8.sv
// Directed bench for the key input PIO (EDGE_TYPE=1, falling capture).
// Default build exercises the plain synchronizer path; with
// KEY_PIO_DEBOUNCE_EN defined it exercises the 4-cycle debounce path.
module tb_test_sys_top_qsys_key_pio_in8;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_port;
  logic       irq;
  int         total = 0;
  int         bad   = 0;

  test_sys_top_qsys_key_pio_in8_if bus ();

  test_sys_top_qsys_key_pio_in8 #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled just after the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(tag, bus.readdata, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  // Write spans exactly one rising edge; returns just after the next falling edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    in_port        = 8'hFF;
    reset_n        = 1'b0;
    tick(2);

    // Reset state
    chk_rd("rst_data", 2'd0, 32'h0);
    chk_rd("rst_a1",   2'd1, 32'h0);
    chk_rd("rst_mask", 2'd2, 32'h0);
    chk_rd("rst_ecap", 2'd3, 32'h0);
    chk_irq("rst_irq", 1'b0);
    reset_n = 1'b1;

`ifndef KEY_PIO_DEBOUNCE_EN
    // Rising edge from reset propagation is not captured in falling mode
    tick(4);
    chk_rd("up_data", 2'd0, 32'hFF);
    chk_rd("up_ecap", 2'd3, 32'h0);

    // Falling edge on bit 0: visible after the third rising edge
    in_port = 8'hFE;
    tick(2);
    chk_rd("fe_data_e2", 2'd0, 32'hFF);
    chk_rd("fe_ecap_e2", 2'd3, 32'h0);
    tick(1);
    chk_rd("fe_data_e3", 2'd0, 32'hFE);
    chk_rd("fe_ecap_e3", 2'd3, 32'h01);
    chk_irq("fe_irq_unmasked", 1'b0);

    wr(2'd2, 32'h01);
    chk_irq("mask_irq", 1'b1);
    chk_rd("mask_rd", 2'd2, 32'h01);

    wr(2'd3, 32'h01);
    chk_rd("clr_ecap", 2'd3, 32'h0);
    chk_irq("clr_irq", 1'b0);

    // Clearing a bit with nothing pending changes nothing
    wr(2'd3, 32'h10);
    chk_rd("clr_idle_ecap", 2'd3, 32'h0);

    // Writes to DATA and address 1 are ignored
    wr(2'd0, 32'h55);
    chk_rd("wr_data_ign", 2'd0, 32'hFE);
    wr(2'd1, 32'h55);
    chk_rd("wr_a1_ign", 2'd1, 32'h0);

    // Masking: bits 1,2 fall, mask only bit 0
    in_port = 8'hF8;
    tick(3);
    chk_rd("m_ecap", 2'd3, 32'h06);
    chk_irq("m_irq_off", 1'b0);
    bus.address    = 2'd2;
    bus.writedata  = 32'h04;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    #1;
    chk_irq("m_irq_pre_edge", 1'b0);
    tick(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    chk_irq("m_irq_on", 1'b1);
    wr(2'd3, 32'h06);
    chk_rd("m_clr_ecap", 2'd3, 32'h0);
    chk_irq("m_clr_irq", 1'b0);

    // Collision: bit 3 falls on the same edge as its clear
    in_port = 8'hF0;
    tick(2);
    wr(2'd3, 32'h08);
    chk_rd("col_ecap", 2'd3, 32'h08);
    chk_rd("col_data", 2'd0, 32'hF0);

    // Reset mid-operation
    tick(1);
    reset_n = 1'b0;
    #1;
    chk_rd("mid_rst_data", 2'd0, 32'h0);
    chk_rd("mid_rst_mask", 2'd2, 32'h0);
    chk_rd("mid_rst_ecap", 2'd3, 32'h0);
    chk_irq("mid_rst_irq", 1'b0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
`else
    // Reset propagation of 0xFF needs a full debounce count
    tick(10);
    chk_rd("db_up_data", 2'd0, 32'hFF);
    chk_rd("db_up_ecap", 2'd3, 32'h0);

    // 3-cycle low glitch on bit 0 never reaches stable
    in_port = 8'hFE;
    tick(3);
    in_port = 8'hFF;
    tick(10);
    chk_rd("db_glitch_data", 2'd0, 32'hFF);
    chk_rd("db_glitch_ecap", 2'd3, 32'h0);

    // Sustained low: changes on the sixth rising edge
    in_port = 8'hFE;
    tick(5);
    chk_rd("db_hold_e5", 2'd0, 32'hFF);
    tick(1);
    chk_rd("db_hold_e6", 2'd0, 32'hFE);
    chk_rd("db_hold_ecap", 2'd3, 32'h01);

    // Reset during a count discards it
    in_port = 8'hFF;
    tick(3);
    reset_n = 1'b0;
    #1;
    chk_rd("db_rst_data", 2'd0, 32'h0);
    chk_rd("db_rst_ecap", 2'd3, 32'h0);
    chk_irq("db_rst_irq", 1'b0);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    chk_rd("db_fresh_e5", 2'd0, 32'h0);
    tick(1);
    chk_rd("db_fresh_e6", 2'd0, 32'hFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
